// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. One full-adder bit cell, built from two half
// adders and an OR, is time-shared across the operand bits. A carry flop
// links one bit to the next. Operands are captured on an accepted Start and
// consumed LSB-first, one bit per clock. The finished {Cout, Sum} is loaded
// into the output registers on the edge that enters DONE, and Done pulses
// for that one cycle.
//
// Parameters:
//   WIDTH  operand/result width, 2..32 (default 4)
//
// Ports:
//   Clk    in   rising-edge clock
//   Reset  in   asynchronous active-high reset
//   Start  in   load request; honoured only in IDLE or DONE
//   A, B   in   operands [WIDTH-1:0]; sampled on the accepting edge only
//   Cin    in   carry-in; sampled on the accepting edge only
//   Busy   out  high while an addition is in progress (state RUN)
//   Done   out  one-cycle pulse when the result is presented (state DONE)
//   Sum    out  registered sum [WIDTH-1:0]; held between operations
//   Cout   out  registered carry-out; held between operations
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   // Bit counter width: ceil(log2(WIDTH)), never narrower than one bit.
   localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // One-hot encoding so Busy and Done are single state flops, not decodes.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b100
   } state_t;

   // Half-adder cell: sum and carry of two bits.
   typedef struct packed {
      logic s;
      logic co;
   } ha_t;

   function automatic ha_t halfadder(input logic x, input logic y);
      ha_t r;
      r.s  = x ^ y;
      r.co = x & y;
      return r;
   endfunction

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rs;
   logic             c;
   logic [CW-1:0]    cnt;

   ha_t  h1;
   ha_t  h2;
   logic sbit;
   logic cnext;

   // Full adder on the current LSBs plus the carry flop.
   always_comb begin
      h1    = halfadder(ra[0], rb[0]);
      h2    = halfadder(h1.s, c);
      sbit  = h2.s;
      cnext = h1.co | h2.co;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  ra    <= A;
                  rb    <= B;
                  c     <= Cin;
                  cnt   <= '0;
                  rs    <= '0;
                  state <= RUN;
               end
            end

            RUN: begin
               rs  <= {sbit, rs[WIDTH-1:1]};
               ra  <= {1'b0, ra[WIDTH-1:1]};
               rb  <= {1'b0, rb[WIDTH-1:1]};
               c   <= cnext;
               cnt <= cnt + 1'b1;
               // The final bit is merged straight into Sum so the outputs
               // never show a partially accumulated value.
               if (cnt == LAST) begin
                  Sum   <= {sbit, rs[WIDTH-1:1]};
                  Cout  <= cnext;
                  state <= DONE;
               end
            end

            DONE: begin
               if (Start) begin
                  ra    <= A;
                  rb    <= B;
                  c     <= Cin;
                  cnt   <= '0;
                  rs    <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = state[1];
   assign Done = state[2];

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder. Drives a WIDTH=4 instance through
// basic, carry, ignored-Start, back-to-back, reset-in-flight and exhaustive
// cases, and a WIDTH=8 instance through directed and random vectors.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic       Clk = 1'b0;
   logic       Reset;

   logic       Start;
   logic [3:0] A, B;
   logic       Cin;
   logic       Busy, Done;
   logic [3:0] Sum;
   logic       Cout;

   logic       Start8;
   logic [7:0] A8, B8;
   logic       Cin8;
   logic       Busy8, Done8;
   logic [7:0] Sum8;
   logic       Cout8;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   serial_adder #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Cin(Cin),
      .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout)
   );

   serial_adder #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .Start(Start8), .A(A8), .B(B8), .Cin(Cin8),
      .Busy(Busy8), .Done(Done8), .Sum(Sum8), .Cout(Cout8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One WIDTH=4 operation: Start for one edge, wait (bounded) for Done,
   // then verify latency and result.
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input string tag);
      int lat;
      A = a; B = b; Cin = cin; Start = 1'b1;
      tick();
      Start = 1'b0;
      check({tag, ".busy0"}, 64'(Busy), 64'd1);
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (Done) begin
            lat = i;
            break;
         end
         check({tag, ".busy"}, 64'(Busy), 64'd1);
      end
      check({tag, ".lat"}, 64'(lat), 64'd4);
      check({tag, ".res"}, 64'({Cout, Sum}), 64'(a) + 64'(b) + 64'(cin));
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input string tag);
      int lat;
      A8 = a; B8 = b; Cin8 = cin; Start8 = 1'b1;
      tick();
      Start8 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (Done8) begin
            lat = i;
            break;
         end
      end
      check({tag, ".lat"}, 64'(lat), 64'd8);
      check({tag, ".res"}, 64'({Cout8, Sum8}), 64'(a) + 64'(b) + 64'(cin));
   endtask

   initial begin
      int ndone;
      Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      Start8 = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0;

      // Reset state, observed before any clock edge.
      #2;
      check("rst.busy", 64'(Busy), 64'd0);
      check("rst.done", 64'(Done), 64'd0);
      check("rst.sum",  64'(Sum),  64'd0);
      check("rst.cout", 64'(Cout), 64'd0);
      check("rst.busy8", 64'(Busy8), 64'd0);
      @(posedge Clk);
      tick();
      Reset = 1'b0;
      tick();

      // Basic add and hold.
      op4(4'd5, 4'd6, 1'b0, "basic");
      tick();
      check("basic.done_drop", 64'(Done), 64'd0);
      check("basic.idle",      64'(Busy), 64'd0);
      check("basic.hold_sum",  64'(Sum),  64'd11);
      check("basic.hold_cout", 64'(Cout), 64'd0);
      tick();
      check("basic.hold2", 64'({Cout, Sum}), 64'd11);

      // Carry chain.
      op4(4'd15, 4'd1,  1'b0, "carry1");
      check("carry1.sum",  64'(Sum),  64'd0);
      check("carry1.cout", 64'(Cout), 64'd1);
      op4(4'd15, 4'd15, 1'b1, "carry2");
      check("carry2.sum",  64'(Sum),  64'd15);
      check("carry2.cout", 64'(Cout), 64'd1);
      tick();
      tick();

      // Start during RUN is ignored.
      A = 4'd3; B = 4'd4; Cin = 1'b0; Start = 1'b1;
      tick();                                   // E0
      Start = 1'b0;
      tick();                                   // E0+1
      A = 4'd9; B = 4'd9; Start = 1'b1;
      tick();                                   // E0+2
      Start = 1'b0;
      check("ign.busy_e2", 64'(Busy), 64'd1);
      tick();                                   // E0+3
      check("ign.nodone_e3", 64'(Done), 64'd0);
      tick();                                   // E0+4
      check("ign.done", 64'(Done), 64'd1);
      check("ign.res",  64'({Cout, Sum}), 64'd7);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (Done) ndone++;
      end
      check("ign.single_done", 64'(ndone), 64'd0);
      check("ign.idle", 64'(Busy), 64'd0);

      // Back-to-back with Start held high.
      A = 4'd1; B = 4'd2; Cin = 1'b0; Start = 1'b1;
      tick();                                   // E0
      check("b2b.busy", 64'(Busy), 64'd1);
      for (int i = 0; i < 3; i++) tick();       // E0+3
      check("b2b.nodone_early", 64'(Done), 64'd0);
      tick();                                   // E0+4
      check("b2b.done1", 64'(Done), 64'd1);
      check("b2b.res1",  64'({Cout, Sum}), 64'd3);
      A = 4'd7; B = 4'd8;
      tick();                                   // E0+5
      check("b2b.reload_busy", 64'(Busy), 64'd1);
      check("b2b.reload_done", 64'(Done), 64'd0);
      check("b2b.hold1",       64'({Cout, Sum}), 64'd3);
      for (int i = 0; i < 3; i++) tick();       // E0+8
      check("b2b.nodone_mid", 64'(Done), 64'd0);
      tick();                                   // E0+9
      Start = 1'b0;
      check("b2b.done2", 64'(Done), 64'd1);
      check("b2b.res2",  64'({Cout, Sum}), 64'd15);
      tick();
      check("b2b.idle", 64'(Busy | Done), 64'd0);

      // Reset in flight.
      A = 4'd9; B = 4'd9; Cin = 1'b0; Start = 1'b1;
      tick();                                   // E0
      Start = 1'b0;
      @(posedge Clk);                           // E0+1
      @(posedge Clk);                           // E0+2
      #3;
      Reset = 1'b1;
      #1;
      check("rmid.busy", 64'(Busy), 64'd0);
      check("rmid.done", 64'(Done), 64'd0);
      check("rmid.sum",  64'(Sum),  64'd0);
      check("rmid.cout", 64'(Cout), 64'd0);
      tick();
      Reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (Done || Busy) ndone++;
      end
      check("rmid.quiet", 64'(ndone), 64'd0);
      op4(4'd2, 4'd2, 1'b0, "rmid.fresh");
      check("rmid.fresh_sum", 64'(Sum), 64'd4);

      // Exhaustive WIDTH=4 sweep (ops run back-to-back from DONE).
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int ci = 0; ci < 2; ci++)
               op4(4'(a), 4'(b), 1'(ci), "sweep");
      tick();
      tick();

      // WIDTH=8: directed corners, then random vectors.
      op8(8'd255, 8'd1,   1'b0, "w8.carry");
      op8(8'd255, 8'd255, 1'b1, "w8.max");
      op8(8'd0,   8'd0,   1'b0, "w8.zero");
      for (int i = 0; i < 24; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), "w8.rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's half-adder cell: two half adders plus an OR form a one-bit full adder, and a carry flip-flop links successive bits. It sits beside the combinational ripple adder as an area-minimal alternative. Operands are loaded on a Start pulse and processed LSB-first, one bit per clock. A registered Sum/Cout result is presented with a one-cycle Done pulse.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2–32.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  load request; sampled only in IDLE or DONE.
- A  in  WIDTH  operand A; sampled on the accepting edge only.
- B  in  WIDTH  operand B; sampled on the accepting edge only.
- Cin  in  1  carry-in; sampled on the accepting edge only.
- Busy  out  1  high while the state is RUN.
- Done  out  1  one-cycle pulse when the state is DONE.
- Sum  out  WIDTH  registered result; holds its value between operations.
- Cout  out  1  registered carry-out; holds its value between operations.

## Operation
- Internal state:
  - shift registers ra and rb (WIDTH bits each).
  - accumulating shift register rs (WIDTH bits).
  - carry flop c.
  - bit counter cnt (ceil(log2(WIDTH)) bits, minimum 1).
  - FSM with states IDLE, RUN, DONE.
- Bit cell:
  - h1 = halfadder(ra[0], rb[0]).
  - h2 = halfadder(h1.Sum, c).
  - sbit = h2.Sum.
  - cnext = h1.Cout | h2.Cout.
- IDLE:
  - Start=1: ra←A, rb←B, c←Cin, cnt←0, rs←0, go to RUN.
  - Start=0: stay in IDLE.
- RUN, on each edge:
  - rs←{sbit, rs[WIDTH-1:1]}.
  - ra and rb shift right by 1, zero-filled.
  - c←cnext, cnt←cnt+1.
  - When cnt==WIDTH-1: Sum←{sbit, rs[WIDTH-1:1]}, Cout←cnext, go to DONE.
  - Start is ignored in RUN. There is no queueing and no error flag.
- DONE lasts exactly one cycle, with Done=1.
  - Start=1: reload exactly as from IDLE and go to RUN (back-to-back operation).
  - Start=0: go to IDLE.
- Sum and Cout change only on the edge that enters DONE. They are never visible in a partially computed state.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1), with no overflow flag.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, and ra, rb, rs, c, cnt all 0.
- Reset has immediate effect, asynchronously, in any state. An operation in flight is discarded and no Done is issued.
- Busy and Done are decoded directly from state flops and are glitch-free registered outputs.
- Latency, with Start sampled at edge E0:
  - Busy=1 after E0 through edge E0+WIDTH.
  - Done=1 and the new Sum/Cout are valid in the cycle after edge E0+WIDTH.
  - Total: WIDTH+1 cycles from Start to Done.
- Throughput with Start held high continuously: one result every WIDTH+1 cycles.
- Operands may change freely after the accepting edge; the block uses its internal copies only.
- A Start pulse during RUN is lost. The upstream agent must wait for Busy=0.

## Test plan
- Basic add, WIDTH=4: A=5, B=6, Cin=0, 1-cycle Start → Busy high 4 cycles, then Done pulse 1 cycle; Sum=11, Cout=0 on the Done cycle and held afterwards.
- Carry chain: A=15, B=1, Cin=0 → Sum=0, Cout=1. Then A=15, B=15, Cin=1 → Sum=15, Cout=1.
- Start during Busy: Start at E0 (A=3, B=4), second Start at E0+2 (A=9, B=9) → single Done at E0+4 cycle with Sum=7; second request ignored, Busy=0 afterwards.
- Back-to-back: Start held high with A=1, B=2 then A=7, B=8 presented on the DONE cycle → Done at cycle 5 (Sum=3, Cout=0) and cycle 10 (Sum=15, Cout=0).
- Reset mid-op: Start with A=9, B=9; assert Reset asynchronously between edges 2 and 3 → Busy, Done, Sum, Cout go to 0 immediately with no Done. A fresh Start with A=2, B=2 afterwards yields Sum=4.
- Exhaustive sweep: all A, B in 0..15 and Cin in {0,1} compared against A+B+Cin; also rerun with WIDTH=8 on random vectors.
